// File: rtl/result_bcd_converter.sv
// result_bcd_converter: sequential double-dabble binary-to-packed-BCD converter with digit count
module result_bcd_converter #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  valid,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [2:0]            num_digits
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] bin_shift_q, bin_shift_d;
    logic [4*DIGITS-1:0] bcd_work_q, bcd_work_d, bcd_out_q, bcd_out_d, adj, shifted;
    logic [CW-1:0] cnt_q, cnt_d;
    logic busy_q, busy_d, valid_q, valid_d;
    logic [2:0] nd_q, nd_d, nd;
    // state and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bin_shift_q <= '0;
            bcd_work_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            bcd_out_q   <= '0;
            nd_q        <= 3'd1;
        end else begin
            state_q     <= state_d;
            bin_shift_q <= bin_shift_d;
            bcd_work_q  <= bcd_work_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            bcd_out_q   <= bcd_out_d;
            nd_q        <= nd_d;
        end
    end
    // add-3 on every digit, shift one bit in, and count significant digits of the shifted value
    always_comb begin
        adj = '0;
        nd  = 3'd1;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = (bcd_work_q[4*i +: 4] >= 4'd5) ? bcd_work_q[4*i +: 4] + 4'd3 : bcd_work_q[4*i +: 4];
        shifted = {adj[4*DIGITS-2:0], bin_shift_q[WIDTH-1]};
        for (int i = 0; i < DIGITS; i++)
            if (shifted[4*i +: 4] != 4'd0) nd = 3'(i + 1);
    end
    // next-state: accept start in IDLE, one double-dabble step per cycle in SHIFT
    always_comb begin
        state_d     = state_q;
        bin_shift_d = bin_shift_q;
        bcd_work_d  = bcd_work_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        bcd_out_d   = bcd_out_q;
        nd_d        = nd_q;
        if (state_q == IDLE) begin
            if (start) begin
                bin_shift_d = bin_in;
                bcd_work_d  = '0;
                cnt_d       = CW'(WIDTH - 1);
                busy_d      = 1'b1;
                state_d     = SHIFT;
            end
        end else begin
            bin_shift_d = {bin_shift_q[WIDTH-2:0], 1'b0};
            bcd_work_d  = shifted;
            cnt_d       = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
            if (cnt_q == '0) begin
                bcd_out_d = shifted;
                nd_d      = nd;
                valid_d   = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        end
    end
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign bcd_out    = bcd_out_q;
    assign num_digits = nd_q;
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: directed and random checks of the BCD converter against a decimal-arithmetic model
module tb_result_bcd_converter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = '0;
    logic        busy, valid;
    logic [19:0] bcd_out;
    logic [2:0]  num_digits;
    int tests = 0;
    int fails = 0;

    result_bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
        .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
        .busy(busy), .valid(valid), .bcd_out(bcd_out), .num_digits(num_digits)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] ref_bcd(int v);
        logic [19:0] r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [2:0] ref_nd(int v);
        int n = 0;
        do begin
            n++;
            v = v / 10;
        end while (v > 0);
        return 3'(n);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(int v);
        start  = 1'b1;
        bin_in = 16'(v);
        tick();
        start  = 1'b0;
        chk("busy_after_accept", 32'(busy), 32'd1);
    endtask

    // waits the 16 edges after an accept; outputs must hold the previous result until the valid pulse
    task automatic wait_valid(int v, logic [19:0] hold_bcd, logic [2:0] hold_nd);
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i < 16) begin
                chk("valid_low_while_busy", 32'(valid), 32'd0);
                chk("busy_high", 32'(busy), 32'd1);
                chk("bcd_hold", 32'(bcd_out), 32'(hold_bcd));
                chk("nd_hold", 32'(num_digits), 32'(hold_nd));
            end
        end
        chk("valid_pulse", 32'(valid), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("bcd_value", 32'(bcd_out), 32'(ref_bcd(v)));
        chk("num_digits", 32'(num_digits), 32'(ref_nd(v)));
    endtask

    task automatic run(int v, logic [19:0] hold_bcd, logic [2:0] hold_nd);
        accept(v);
        wait_valid(v, hold_bcd, hold_nd);
        tick();
        chk("valid_one_cycle", 32'(valid), 32'd0);
        chk("bcd_held_after", 32'(bcd_out), 32'(ref_bcd(v)));
    endtask

    initial begin
        int vals[6];
        int nvalid;
        int prev;
        vals = '{0, 65535, 1024, 81, 1, 12345};
        // reset then idle
        rst = 1'b1;
        tick();
        tick();
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_nd", 32'(num_digits), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_state", {bcd_out, num_digits, busy, valid}, {20'h0, 3'd1, 1'b0, 1'b0});
        end
        // directed values: zero, max, typical exponent results
        prev = 0;
        for (int k = 0; k < 6; k++) begin
            run(vals[k], ref_bcd(prev), ref_nd(prev));
            prev = vals[k];
        end
        // start while busy is ignored
        accept(1024);
        nvalid = 0;
        for (int i = 1; i <= 20; i++) begin
            start  = (i == 5);
            bin_in = (i == 5) ? 16'd999 : 16'd1024;
            tick();
            if (valid) begin
                nvalid++;
                chk("busy_start_valid_edge", 32'(i), 32'd16);
                chk("busy_start_bcd", 32'(bcd_out), 32'h01024);
            end
        end
        start = 1'b0;
        chk("busy_start_one_valid", 32'(nvalid), 32'd1);
        chk("busy_start_bcd_final", 32'(bcd_out), 32'h01024);
        // back-to-back: second start lands in the valid cycle of the first
        accept(255);
        wait_valid(255, 20'h01024, 3'd4);
        accept(4096);
        chk("b2b_valid_dropped", 32'(valid), 32'd0);
        chk("b2b_bcd_stable", 32'(bcd_out), 32'h00255);
        wait_valid(4096, 20'h00255, 3'd3);
        tick();
        // reset mid-operation
        accept(12345);
        for (int i = 0; i < 7; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bcd", 32'(bcd_out), 32'h0);
        chk("abort_nd", 32'(num_digits), 32'd1);
        nvalid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid) nvalid++;
        end
        chk("abort_no_valid", 32'(nvalid), 32'd0);
        run(12345, 20'h0, 3'd1);
        // random values
        prev = 12345;
        for (int k = 0; k < 20; k++) begin
            int v;
            v = int'($urandom_range(0, 65535));
            run(v, ref_bcd(prev), ref_nd(prev));
            prev = v;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/result_bcd_converter.md
Name: result_bcd_converter

Overview:
- Downstream stage of the exponent datapath.
- Captures the final binary result when the controller loads its output register, and converts it to packed BCD with a sequential double-dabble algorithm (one bit per cycle).
- Presents the digits, plus a count of significant digits, to the LCD controller with a one-cycle valid pulse.

Parameters:
- WIDTH, 16, bit width of the binary result input.
- DIGITS, 5, number of BCD digits produced. Must be >= ceil(WIDTH*log10(2)); 5 is sufficient for 16 bits.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset. Synchronous, active-high.
- start  input  1  conversion request. Driven by the controller's output-load strobe.
- bin_in  input  WIDTH  binary result. Sampled only on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  one-cycle pulse: bcd_out and num_digits are new.
- bcd_out  output  4*DIGITS  packed BCD, digit 0 in bits [3:0], most significant digit at the top.
- num_digits  output  3  significant digit count, range 1..DIGITS.

Behaviour:
- Reset (rst high at a posedge):
  - state <= IDLE.
  - busy, valid, and the shift/BCD working registers <= 0.
  - bcd_out <= 0.
  - num_digits <= 1.
  - Reset overrides everything. Asserting it mid-conversion aborts the conversion, and no valid pulse is issued.
- States: IDLE, SHIFT.
- IDLE:
  - If start=1, then at this edge: bin_shift <= bin_in, bcd_work <= 0, bit counter <= WIDTH-1, busy <= 1, state <= SHIFT.
  - If start=0, the block holds.
- SHIFT, one step per cycle:
  - For each 4-bit digit of bcd_work, add 3 if the digit is >= 5 (all digits in parallel).
  - Then shift {bcd_work, bin_shift} left by 1; the MSB of bin_shift enters bcd_work bit 0.
  - If counter != 0, decrement it.
  - If counter == 0 (this is the WIDTH-th shift):
    - bcd_out <= final shifted BCD value.
    - num_digits <= index of the highest nonzero digit + 1, or 1 if all digits are zero.
    - valid <= 1, busy <= 0, state <= IDLE.
- Latency: valid is high in the cycle exactly WIDTH clock edges after the edge that accepted start (16 for the default).
- valid is high for exactly one cycle; it is 0 in every other cycle.
- bcd_out and num_digits hold their values until the next completion or reset.
- start while busy=1: ignored; it is not queued and bin_in is not re-sampled.
- start in the valid cycle: the state is already IDLE, so start is accepted. A new conversion begins and the previous bcd_out remains stable until the next completion.
- Arithmetic: add-3 is 4-bit, with no carry out of the digit. Digits never exceed 9 after the shift, given the DIGITS constraint. There is no overflow output.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset then idle: rst high 2 cycles, then low with start=0 for 20 cycles -> bcd_out=0x00000, num_digits=1, valid=0, busy=0 throughout.
- Zero and maximum values:
  - bin_in=0 with a 1-cycle start -> busy high for 16 cycles; valid pulses once, 16 edges after start; bcd_out=0x00000, num_digits=1.
  - bin_in=65535 -> bcd_out=0x65535, num_digits=5.
- Typical exponent results:
  - 2^10=1024 -> bcd_out=0x01024, num_digits=4.
  - 3^4=81 -> bcd_out=0x00081, num_digits=2.
  - 1 -> bcd_out=0x00001, num_digits=1.
- start while busy: start with 1024, then pulse start with bin_in=999 on cycle 5 -> exactly one valid, with bcd_out=0x01024.
- Back-to-back: start with 255; assert start with 4096 in the valid cycle of the first conversion -> first valid shows 0x00255 (num_digits=3); bcd_out holds 0x00255 until the second valid, which shows 0x04096 (num_digits=4) 16 edges later.
- Reset mid-operation: start with 12345, assert rst on cycle 8 -> busy=0 next cycle, no valid ever issued, bcd_out=0x00000 and num_digits=1. A subsequent start with 12345 yields 0x12345 and num_digits=5.
